ofm_sparse_encoder: RTL and testbench
=====================================

// Module: ofm_sparse_encoder
// PURPOSE
// - Downstream of the voting convolution stage: on its o_done, reads the finished OFM BRAM (port A) and
//   re-encodes it into next-layer sparse form: non-null value list (IFM BRAM) + linear-position list (NNVR BRAM).
// - Per value: arithmetic right shift, saturate to the 30-bit IFM word, optional ReLU; zero results dropped.
// - Reports the non-null count for the next layer's FMVALUES/o_values.
// PARAMETERS
// - OUT_SIZE   4                  OFM side length; N = OUT_SIZE**2 words processed per run
// - IN_WIDTH   `OUTPUT_DSP_WIDTH  signed OFM word width (48)
// - OUT_WIDTH  30                 signed IFM word width written to next layer
// - SHIFT      0                  arithmetic right shift applied before saturation (0..IN_WIDTH-1)
// PORTS  (AW = $clog2(OUT_SIZE**2)+1)
// - i_clk            in   1          clock; one clock domain, all logic on rising edge
// - i_rst            in   1          synchronous, active-high reset
// - i_start          in   1          single-cycle pulse; driven from convolution o_done
// - o_ofm_r_addr     out  AW         OFM BRAM read address
// - i_ofm_data       in   IN_WIDTH   OFM BRAM read data, signed; valid 1 cycle after address
// - o_ifm_w_en       out  1          next-layer IFM BRAM write enable
// - o_ifm_w_addr     out  AW         IFM write address (= non-null index)
// - o_ifm_w_data     out  OUT_WIDTH  processed value, signed
// - o_nnvr_w_en      out  1          NNVR BRAM write enable (always equals o_ifm_w_en)
// - o_nnvr_w_addr    out  AW         NNVR write address (= o_ifm_w_addr)
// - o_nnvr_w_data    out  AW         linear OFM position (row*OUT_SIZE+col) of the value
// - o_nnz            out  AW         non-null count; valid when o_done, held until next accepted start
// - o_busy           out  1          high from start acceptance through o_done cycle
// - o_done           out  1          one-cycle pulse at end of run
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-run aborts immediately; no further writes.
// - FSM: IDLE -(i_start)-> READ -(addr N-1 issued)-> DRAIN -(last slot written)-> DONE -> IDLE.
// - i_start ignored while o_busy=1 (no restart, no queuing).
// - READ: o_ofm_r_addr = 0..N-1, one per cycle, no gaps; address held at 0 in IDLE.
// - Pipeline: addr cycle t -> data cycle t+1 -> registered write slot cycle t+2 (position tracked in parallel).
// - Arithmetic: s = i_ofm_data >>> SHIFT; if s > 2^(OUT_WIDTH-1)-1 -> max; if s < -2^(OUT_WIDTH-1) -> min.
// - Write slot taken only if result != 0; write index then increments; zero results produce no write.
// - Latency: start sampled at edge 0 -> o_done high in cycle N+3; o_nnz/o_done registered same edge.
// - Bounds: all-zero OFM -> no writes, o_nnz=0, o_done still pulses; all non-null -> N writes, last
//   address N-1, o_nnz=N (AW bits suffice). Saturation never wraps. Position and index never exceed N-1.
// CONFIGURATION
// - `SPARSE_RELU_EN defined: results < 0 forced to 0 before zero test, hence dropped (ReLU fused).
// - Not defined: negative saturated results are kept and written like positives.
// STRUCTURE
// - Shared package conv_pkg: OUTPUT_DSP_WIDTH, IFM_DATA_WIDTH=30, FSM state enum
//   (IDLE/READ/DRAIN/DONE), addr-width helper constant.
// - One combinational sub-module ofm_requant (shift + saturate + optional ReLU); FSM, counters and
//   write registers in this module.
// TESTING  (OUT_SIZE=4, SHIFT=0, N=16)
// - Reset mid-run: assert i_rst at cycle 6 -> all outputs 0 next cycle, no writes after; fresh start works.
// - OFM all 0 -> zero writes, o_nnz=0, o_done pulse in cycle 19 (start at 0).
// - OFM = 1..16 -> 16 writes, IFM data 1..16, NNVR data 0..15, o_nnz=16, o_done cycle 19.
// - OFM zeros except pos 3 = 7, pos 10 = -5: without RELU -> writes (0:7,pos3),(1:-5,pos10), o_nnz=2;
//   with `SPARSE_RELU_EN -> only (0:7,pos3), o_nnz=1.
// - Saturation: pos 0 = 2^40, pos 1 = -2^40 -> data 536870911 and -536870912; SHIFT=4, value 0x1F -> 1.
// - i_start re-pulsed at cycle 5 of a run -> ignored; exactly one o_done; write stream unchanged.

Source files
------------

// File: rtl/ofm_sparse_encoder_pkg.sv
// Shared types and constants for the OFM sparse encoder.
package ofm_sparse_encoder_pkg;

   localparam int OUTPUT_DSP_WIDTH = 48;

   localparam int IFM_DATA_WIDTH = 30;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      DONE
   } enc_state_t;

   // One extra bit so a count of OUT_SIZE**2 still fits.
   function automatic int enc_addr_width(input int out_size);
      return $clog2(out_size * out_size) + 1;
   endfunction

endpackage

// File: rtl/ofm_sparse_encoder_if.sv
// Bus bundle between the OFM BRAM, the next-layer IFM/NNVR BRAMs and the sparse encoder.
// The encoder uses the slave modport; the surrounding system uses master.
interface ofm_sparse_encoder_if #(
   parameter int AW        = 5,
   parameter int IN_WIDTH  = 48,
   parameter int OUT_WIDTH = 30
);

   logic                        i_start;
   logic [AW-1:0]               o_ofm_r_addr;
   logic signed [IN_WIDTH-1:0]  i_ofm_data;
   logic                        o_ifm_w_en;
   logic [AW-1:0]               o_ifm_w_addr;
   logic signed [OUT_WIDTH-1:0] o_ifm_w_data;
   logic                        o_nnvr_w_en;
   logic [AW-1:0]               o_nnvr_w_addr;
   logic [AW-1:0]               o_nnvr_w_data;
   logic [AW-1:0]               o_nnz;
   logic                        o_busy;
   logic                        o_done;

   modport slave (
      input  i_start,
      input  i_ofm_data,
      output o_ofm_r_addr,
      output o_ifm_w_en,
      output o_ifm_w_addr,
      output o_ifm_w_data,
      output o_nnvr_w_en,
      output o_nnvr_w_addr,
      output o_nnvr_w_data,
      output o_nnz,
      output o_busy,
      output o_done
   );

   modport master (
      output i_start,
      output i_ofm_data,
      input  o_ofm_r_addr,
      input  o_ifm_w_en,
      input  o_ifm_w_addr,
      input  o_ifm_w_data,
      input  o_nnvr_w_en,
      input  o_nnvr_w_addr,
      input  o_nnvr_w_data,
      input  o_nnz,
      input  o_busy,
      input  o_done
   );

endinterface

// File: rtl/ofm_sparse_encoder_requant.sv
// Combinational requantiser: arithmetic shift, saturation to OUT_WIDTH, optional fused ReLU.
// Build option: SPARSE_RELU_EN clamps negative results to zero so they are dropped.
module ofm_sparse_encoder_requant #(
   parameter int IN_WIDTH  = 48,
   parameter int OUT_WIDTH = 30,
   parameter int SHIFT     = 0
) (
   input  logic signed [IN_WIDTH-1:0]  data,
   output logic signed [OUT_WIDTH-1:0] value,
   output logic                        keep
);

   logic signed [IN_WIDTH-1:0] shifted;
   logic                       fits;

   // The value fits when every bit above the target sign bit copies it.
   always_comb begin
      shifted = data >>> SHIFT;
      fits    = (&shifted[IN_WIDTH-1:OUT_WIDTH-1]) || !(|shifted[IN_WIDTH-1:OUT_WIDTH-1]);
      value   = shifted[OUT_WIDTH-1:0];
      if (!fits) begin
         value = shifted[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
`ifdef SPARSE_RELU_EN
      if (value[OUT_WIDTH-1]) begin
         value = '0;
      end
`endif
      keep = (value != '0);
   end

endmodule

// File: rtl/ofm_sparse_encoder.sv
// Re-encodes a finished OFM into sparse form (value list + linear position list) for the next layer.
// Build option: SPARSE_RELU_EN (applied inside the requantiser).
module ofm_sparse_encoder
   import ofm_sparse_encoder_pkg::*;
#(
   parameter int OUT_SIZE  = 4,
   parameter int IN_WIDTH  = OUTPUT_DSP_WIDTH,
   parameter int OUT_WIDTH = IFM_DATA_WIDTH,
   parameter int SHIFT     = 0
) (
   input logic               i_clk,
   input logic               i_rst,
   ofm_sparse_encoder_if.slave bus
);

   localparam int            AW        = enc_addr_width(OUT_SIZE);
   localparam int            N         = OUT_SIZE * OUT_SIZE;
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   enc_state_t state, next_state;
   logic       accept;
   logic       read_last;

   logic [AW-1:0] rd_addr;
   logic [AW-1:0] pos_d;
   logic          rd_valid_d;
   logic          rd_last_d;
   logic          slot_last;

   logic                        w_en;
   logic [AW-1:0]               w_addr;
   logic [AW-1:0]               w_pos;
   logic signed [OUT_WIDTH-1:0] w_data;
   logic [AW-1:0]               wr_idx;

   logic          busy;
   logic          done;
   logic [AW-1:0] nnz;

   logic signed [OUT_WIDTH-1:0] req_value;
   logic                        req_keep;

   ofm_sparse_encoder_requant #(
      .IN_WIDTH  (IN_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_requant (
      .data  (bus.i_ofm_data),
      .value (req_value),
      .keep  (req_keep)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Start is accepted only when fully idle, including the o_done cycle.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      read_last  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_start && !busy) begin
               accept     = 1'b1;
               next_state = READ;
            end
         end
         READ: begin
            read_last = (rd_addr == LAST_ADDR);
            if (read_last) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (slot_last) begin
               next_state = DONE;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Read side: the position of each address rides one cycle behind it, aligned with the BRAM data.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_addr    <= '0;
         pos_d      <= '0;
         rd_valid_d <= 1'b0;
         rd_last_d  <= 1'b0;
      end else begin
         rd_valid_d <= (state == READ);
         rd_last_d  <= read_last;
         pos_d      <= rd_addr;
         if (state == READ && !read_last) begin
            rd_addr <= rd_addr + 1'b1;
         end else begin
            rd_addr <= '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         w_en      <= 1'b0;
         w_addr    <= '0;
         w_pos     <= '0;
         w_data    <= '0;
         wr_idx    <= '0;
         slot_last <= 1'b0;
      end else begin
         slot_last <= rd_valid_d && rd_last_d;
         w_en      <= 1'b0;
         if (accept) begin
            wr_idx <= '0;
         end else if (rd_valid_d && req_keep) begin
            w_en   <= 1'b1;
            w_addr <= wr_idx;
            w_pos  <= pos_d;
            w_data <= req_value;
            wr_idx <= wr_idx + 1'b1;
         end
      end
   end

   // Busy spans the o_done cycle so a start pulse coincident with done is ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         nnz  <= '0;
      end else begin
         done <= (state == DONE);
         if (accept) begin
            busy <= 1'b1;
            nnz  <= '0;
         end else if (done) begin
            busy <= 1'b0;
         end
         if (state == DONE) begin
            nnz <= wr_idx;
         end
      end
   end

   assign bus.o_ofm_r_addr  = rd_addr;
   assign bus.o_ifm_w_en    = w_en;
   assign bus.o_ifm_w_addr  = w_addr;
   assign bus.o_ifm_w_data  = w_data;
   assign bus.o_nnvr_w_en   = w_en;
   assign bus.o_nnvr_w_addr = w_addr;
   assign bus.o_nnvr_w_data = w_pos;
   assign bus.o_nnz         = nnz;
   assign bus.o_busy        = busy;
   assign bus.o_done        = done;

endmodule

// File: tb/tb_ofm_sparse_encoder.sv
// Directed bench for ofm_sparse_encoder (OUT_SIZE=4); a second instance uses SHIFT=4.
// Expectations follow SPARSE_RELU_EN when it is defined.
module tb_ofm_sparse_encoder;

   localparam int AW   = 5;
   localparam int INW  = 48;
   localparam int OUTW = 30;

   typedef struct packed {
      logic [AW-1:0]   r_addr;
      logic            ifm_en;
      logic [AW-1:0]   ifm_addr;
      logic [OUTW-1:0] ifm_data;
      logic            nnvr_en;
      logic [AW-1:0]   nnvr_addr;
      logic [AW-1:0]   nnvr_data;
      logic [AW-1:0]   nnz;
      logic            busy;
      logic            done;
   } obs_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ofm_sparse_encoder_if #(.AW(AW), .IN_WIDTH(INW), .OUT_WIDTH(OUTW)) bus0 ();
   ofm_sparse_encoder_if #(.AW(AW), .IN_WIDTH(INW), .OUT_WIDTH(OUTW)) bus1 ();

   ofm_sparse_encoder #(.OUT_SIZE(4), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .SHIFT(0)) dut0 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus0)
   );

   ofm_sparse_encoder #(.OUT_SIZE(4), .IN_WIDTH(INW), .OUT_WIDTH(OUTW), .SHIFT(4)) dut1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1)
   );

   logic signed [INW-1:0] ofm_mem [16];

   // Synchronous-read OFM BRAM model, one read port per encoder instance.
   always @(posedge clk) begin
      bus0.i_ofm_data <= ofm_mem[bus0.o_ofm_r_addr[3:0]];
      bus1.i_ofm_data <= ofm_mem[bus1.o_ofm_r_addr[3:0]];
   end

   int compared_n   = 0;
   int mismatched_n = 0;

   logic [OUTW-1:0] cap_data [$];
   logic [AW-1:0]   cap_addr [$];
   logic [AW-1:0]   cap_pos  [$];
   logic [OUTW-1:0] exp_data [$];
   logic [AW-1:0]   exp_pos  [$];
   int              done_cycle;
   int              done_count;
   int              busy_cycles;
   int              addr_errs;
   int              link_errs;
   int              post_reset_writes;
   logic [AW-1:0]   nnz_at_done;
   logic [63:0]     reset_snap;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared_n++;
      assert (observed === expected)
      else begin
         mismatched_n++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic obs_t sample(input int sel);
      obs_t o;
      if (sel == 0) begin
         o.r_addr    = bus0.o_ofm_r_addr;
         o.ifm_en    = bus0.o_ifm_w_en;
         o.ifm_addr  = bus0.o_ifm_w_addr;
         o.ifm_data  = bus0.o_ifm_w_data;
         o.nnvr_en   = bus0.o_nnvr_w_en;
         o.nnvr_addr = bus0.o_nnvr_w_addr;
         o.nnvr_data = bus0.o_nnvr_w_data;
         o.nnz       = bus0.o_nnz;
         o.busy      = bus0.o_busy;
         o.done      = bus0.o_done;
      end else begin
         o.r_addr    = bus1.o_ofm_r_addr;
         o.ifm_en    = bus1.o_ifm_w_en;
         o.ifm_addr  = bus1.o_ifm_w_addr;
         o.ifm_data  = bus1.o_ifm_w_data;
         o.nnvr_en   = bus1.o_nnvr_w_en;
         o.nnvr_addr = bus1.o_nnvr_w_addr;
         o.nnvr_data = bus1.o_nnvr_w_data;
         o.nnz       = bus1.o_nnz;
         o.busy      = bus1.o_busy;
         o.done      = bus1.o_done;
      end
      return o;
   endfunction

   task automatic setStart(input int sel, input logic v);
      if (sel == 0) bus0.i_start = v;
      else          bus1.i_start = v;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 16; i++) ofm_mem[i] = '0;
   endtask

   // Pulses start, then observes a fixed 30-cycle window; k counts cycles from the start edge.
   task automatic applyStimulus(input int sel, input int repulse_at, input int reset_at);
      obs_t o;
      cap_data.delete();
      cap_addr.delete();
      cap_pos.delete();
      done_cycle        = -1;
      done_count        = 0;
      busy_cycles       = 0;
      addr_errs         = 0;
      link_errs         = 0;
      post_reset_writes = 0;
      nnz_at_done       = '0;
      reset_snap        = '1;
      @(negedge clk);
      setStart(sel, 1'b1);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         o = sample(sel);
         if (k == repulse_at) setStart(sel, 1'b1);
         else if (k == 0 || k == repulse_at + 1) setStart(sel, 1'b0);
         if (o.ifm_en) begin
            cap_data.push_back(o.ifm_data);
            cap_addr.push_back(o.ifm_addr);
            cap_pos.push_back(o.nnvr_data);
            if (reset_at >= 0 && k > reset_at) post_reset_writes++;
         end
         if (o.nnvr_en !== o.ifm_en || o.nnvr_addr !== o.ifm_addr) link_errs++;
         if (o.busy) busy_cycles++;
         if (reset_at < 0 && k < 16 && o.r_addr !== AW'(k)) addr_errs++;
         if (o.done) begin
            done_count++;
            done_cycle  = k;
            nnz_at_done = o.nnz;
         end
         if (k == reset_at) rst = 1'b1;
         if (reset_at >= 0 && k == reset_at + 1) begin
            reset_snap = 64'(o);
            rst        = 1'b0;
         end
      end
   endtask

   task automatic compareWrites(input string tag);
      checkOutput({tag, " writes"}, 64'(cap_data.size()), 64'(exp_data.size()));
      for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
         checkOutput($sformatf("%s data[%0d]", tag, i), 64'(cap_data[i]), 64'(exp_data[i]));
         checkOutput($sformatf("%s pos[%0d]", tag, i), 64'(cap_pos[i]), 64'(exp_pos[i]));
         checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(cap_addr[i]), 64'(i));
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus0.i_start = 1'b0;
      bus1.i_start = 1'b0;
      clearMem();
      repeat (3) @(negedge clk);
      checkOutput("reset_state dut0", 64'(sample(0)), 64'd0);
      checkOutput("reset_state dut1", 64'(sample(1)), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Mid-run reset: five writes (cycles 2..6) land before the reset edge.
      for (int i = 0; i < 16; i++) ofm_mem[i] = INW'(i + 1);
      applyStimulus(0, -1, 6);
      checkOutput("reset writes_before", 64'(cap_data.size()), 64'd5);
      checkOutput("reset writes_after", 64'(post_reset_writes), 64'd0);
      checkOutput("reset outputs_zero", reset_snap, 64'd0);
      checkOutput("reset no_done", 64'(done_count), 64'd0);

      exp_data.delete();
      exp_pos.delete();
      for (int i = 0; i < 16; i++) begin
         exp_data.push_back(OUTW'(i + 1));
         exp_pos.push_back(AW'(i));
      end
      applyStimulus(0, -1, -1);
      compareWrites("dense");
      checkOutput("dense done_cycle", 64'(done_cycle), 64'd19);
      checkOutput("dense done_count", 64'(done_count), 64'd1);
      checkOutput("dense nnz", 64'(nnz_at_done), 64'd16);
      checkOutput("dense busy_cycles", 64'(busy_cycles), 64'd20);
      checkOutput("dense addr_seq_errs", 64'(addr_errs), 64'd0);
      checkOutput("dense nnvr_link_errs", 64'(link_errs), 64'd0);

      clearMem();
      exp_data.delete();
      exp_pos.delete();
      applyStimulus(0, -1, -1);
      compareWrites("zeros");
      checkOutput("zeros nnz", 64'(nnz_at_done), 64'd0);
      checkOutput("zeros done_cycle", 64'(done_cycle), 64'd19);
      checkOutput("zeros done_count", 64'(done_count), 64'd1);

      ofm_mem[3]  = 48'sd7;
      ofm_mem[10] = -48'sd5;
      exp_data.delete();
      exp_pos.delete();
      exp_data.push_back(30'd7);
      exp_pos.push_back(5'd3);
`ifndef SPARSE_RELU_EN
      exp_data.push_back(30'h3FFF_FFFB);
      exp_pos.push_back(5'd10);
`endif
      applyStimulus(0, -1, -1);
      compareWrites("sparse");
      checkOutput("sparse nnz", 64'(nnz_at_done), 64'(exp_data.size()));
      checkOutput("sparse done_cycle", 64'(done_cycle), 64'd19);

      // Start re-pulsed mid-run must not change anything.
      applyStimulus(0, 5, -1);
      compareWrites("repulse");
      checkOutput("repulse done_count", 64'(done_count), 64'd1);
      checkOutput("repulse done_cycle", 64'(done_cycle), 64'd19);
      checkOutput("repulse nnz", 64'(nnz_at_done), 64'(exp_data.size()));

      clearMem();
      ofm_mem[0] = 48'h0100_0000_0000;
      ofm_mem[1] = 48'hFF00_0000_0000;
      exp_data.delete();
      exp_pos.delete();
      exp_data.push_back(30'h1FFF_FFFF);
      exp_pos.push_back(5'd0);
`ifndef SPARSE_RELU_EN
      exp_data.push_back(30'h2000_0000);
      exp_pos.push_back(5'd1);
`endif
      applyStimulus(0, -1, -1);
      compareWrites("saturate");
      checkOutput("saturate nnz", 64'(nnz_at_done), 64'(exp_data.size()));

      clearMem();
      ofm_mem[0] = 48'sh1F;
      ofm_mem[5] = -48'sd16;
      ofm_mem[7] = 48'sh0F;
      exp_data.delete();
      exp_pos.delete();
      exp_data.push_back(30'd1);
      exp_pos.push_back(5'd0);
`ifndef SPARSE_RELU_EN
      exp_data.push_back(30'h3FFF_FFFF);
      exp_pos.push_back(5'd5);
`endif
      applyStimulus(1, -1, -1);
      compareWrites("shift4");
      checkOutput("shift4 nnz", 64'(nnz_at_done), 64'(exp_data.size()));
      checkOutput("shift4 done_cycle", 64'(done_cycle), 64'd19);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_n, mismatched_n);
      $finish;
   end

endmodule
